// File: rtl/mono_stream_scaler.sv
// mono_stream_scaler: RGB pixel stream -> 1-bit nearest-neighbour downscaled framebuffer writes.
// Define MONO_STREAM_SCALER_DITHER_EN for a 4x4 ordered-dither threshold.
module mono_stream_scaler #(
  parameter int IN_W           = 800,
  parameter int IN_H           = 600,
  parameter int OUT_W          = 512,
  parameter int OUT_H          = 342,
  parameter int ADDR_W         = $clog2(OUT_W*OUT_H),
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vs,
  input  logic              de,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic [7:0]        threshold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_short
);

  localparam int XW  = $clog2(OUT_W+1) + 1;
  localparam int YW  = $clog2(OUT_H+1) + 1;
  localparam int AXW = $clog2(IN_W+OUT_W) + 1;
  localparam int AYW = $clog2(IN_H+OUT_H) + 1;
  localparam int IXW = $clog2(IN_W+1) + 1;
  localparam int IYW = $clog2(IN_H+1) + 1;

  localparam logic [AXW-1:0] AX_IN  = AXW'(IN_W);
  localparam logic [AXW-1:0] AX_OUT = AXW'(OUT_W);
  localparam logic [AYW-1:0] AY_IN  = AYW'(IN_H);
  localparam logic [AYW-1:0] AY_OUT = AYW'(OUT_H);
  localparam logic [IXW-1:0] IX_IN  = IXW'(IN_W);
  localparam logic [IYW-1:0] IY_IN  = IYW'(IN_H);
  localparam logic [XW-1:0]  LAST_X = XW'(OUT_W-1);
  localparam logic [YW-1:0]  LAST_Y = YW'(OUT_H-1);

  logic              vs_q, de_q, vs_d, de_d;
  logic [7:0]        r_q, g_q, b_q;
  logic              in_frame, line_active, line_emit;
  logic [AXW-1:0]    acc_x;
  logic [AYW-1:0]    acc_y;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic [IXW-1:0]    in_x;
  logic [IYW-1:0]    in_y;
  logic [ADDR_W-1:0] row_base;
  logic [7:0]        thr_lat;

  logic              vs_lead, de_rise, de_fall;
  logic              y_ok, y_emit, le, pix_ok, pe, w, last;
  logic [AYW-1:0]    ay_sum;
  logic [AXW-1:0]    ax, ax_sum;
  logic [XW-1:0]     ox;
  logic [IXW-1:0]    ix;
  logic [9:0]        luma_sum;
  logic [7:0]        luma, thr_eff;
  logic              mono;

`ifdef MONO_STREAM_SCALER_DITHER_EN
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };
  logic signed [10:0] dsum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      vs_q <= (vs == VS_ACTIVE_HIGH);
      de_q <= de;
      r_q  <= r;
      g_q  <= g;
      b_q  <= b;
    end
  end

  always_comb begin
    vs_lead = vs_q & ~vs_d;
    de_rise = de_q & ~de_d & in_frame & ~vs_lead;
    de_fall = ~de_q & de_d & line_active & in_frame & ~vs_lead;
    ay_sum  = acc_y + AY_OUT;
    y_ok    = in_y < IY_IN;
    y_emit  = y_ok && (ay_sum >= AY_IN);
    le      = de_rise ? y_emit : line_emit;
    ax      = de_rise ? '0 : acc_x;
    ox      = de_rise ? '0 : out_x;
    ix      = de_rise ? '0 : in_x;
    pix_ok  = de_q & in_frame & ~vs_lead
            & (de_rise | line_active) & (ix < IX_IN);
    ax_sum  = ax + AX_OUT;
    pe      = ax_sum >= AX_IN;
    w       = pix_ok & le & pe;
    last    = w & (out_y == LAST_Y) & (ox == LAST_X);
    luma_sum = {2'b00, r_q} + {1'b0, g_q, 1'b0} + {2'b00, b_q};
    luma     = 8'(luma_sum >> 2);
`ifdef MONO_STREAM_SCALER_DITHER_EN
    dsum = $signed({3'b000, thr_lat})
         + $signed({3'b000, BAYER[{out_y[1:0], ox[1:0]}], 4'b0000})
         - 11'sd120;
    if (dsum < 11'sd0)
      thr_eff = 8'd0;
    else if (dsum > 11'sd255)
      thr_eff = 8'hFF;
    else
      thr_eff = dsum[7:0];
`else
    thr_eff = thr_lat;
`endif
    mono = luma >= thr_eff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_d        <= 1'b0;
      de_d        <= 1'b0;
      in_frame    <= 1'b0;
      line_active <= 1'b0;
      line_emit   <= 1'b0;
      acc_x       <= '0;
      acc_y       <= '0;
      out_x       <= '0;
      out_y       <= '0;
      in_x        <= '0;
      in_y        <= '0;
      row_base    <= '0;
      thr_lat     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_short <= 1'b0;
    end else begin
      vs_d        <= vs_q;
      de_d        <= de_q;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      wr_en       <= 1'b0;
      if (vs_lead) begin
        // Restart: any line in flight is abandoned
        acc_y       <= '0;
        out_y       <= '0;
        in_y        <= '0;
        row_base    <= '0;
        thr_lat     <= threshold;
        frame_start <= 1'b1;
        in_frame    <= 1'b1;
        line_active <= 1'b0;
        line_emit   <= 1'b0;
        if (in_frame)
          frame_short <= 1'b1;
      end else begin
        if (de_rise) begin
          line_active <= 1'b1;
          line_emit   <= y_emit;
          if (y_ok) begin
            in_y  <= in_y + IYW'(1);
            acc_y <= y_emit ? ay_sum - AY_IN : ay_sum;
          end
        end
        if (pix_ok) begin
          acc_x <= pe ? ax_sum - AX_IN : ax_sum;
          in_x  <= ix + IXW'(1);
          out_x <= w ? ox + XW'(1) : ox;
        end
        // Counters advance even when enable masks the strobe
        if (w) begin
          wr_en   <= enable;
          wr_addr <= row_base + ADDR_W'(ox);
          wr_data <= mono;
        end
        if (last) begin
          frame_done  <= 1'b1;
          in_frame    <= 1'b0;
          frame_short <= 1'b0;
        end
        if (de_fall) begin
          line_active <= 1'b0;
          if (line_emit) begin
            out_y    <= out_y + YW'(1);
            row_base <= row_base + ADDR_W'(OUT_W);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mono_stream_scaler.sv
// tb_mono_stream_scaler: random RGB frames against an arithmetic downscale model.
// Uses a reduced geometry so several complete frames fit in a short run.
`timescale 1ns/1ps
module tb_mono_stream_scaler;

  localparam int IN_W  = 20;
  localparam int IN_H  = 12;
  localparam int OUT_W = 13;
  localparam int OUT_H = 7;
  localparam int AW    = 7;
  localparam int LAST  = OUT_W*OUT_H - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          vs = 1'b0;
  logic          de = 1'b0;
  logic [7:0]    r = '0, g = '0, b = '0;
  logic [7:0]    threshold = '0;
  logic          wr_en, wr_data, frame_start, frame_done, frame_short;
  logic [AW-1:0] wr_addr;

  always #5 clk = ~clk;

  mono_stream_scaler #(
    .IN_W(IN_W), .IN_H(IN_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
    .ADDR_W(AW), .VS_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vs(vs), .de(de), .r(r), .g(g), .b(b),
    .threshold(threshold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_start(frame_start), .frame_done(frame_done),
    .frame_short(frame_short)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

`ifdef MONO_STREAM_SCALER_DITHER_EN
  localparam int BAYER [16] = '{0, 8, 2, 10, 12, 4, 14, 6,
                                3, 11, 1, 9, 15, 7, 13, 5};
`endif

  // Model state
  int exp_q[$];
  int exp_t[$];
  bit m_in_frame = 0;
  bit m_short    = 0;
  int m_thr      = 0;
  int m_line     = 0;
  int m_starts   = 0;
  int m_dones    = 0;
  int m_wr       = 0;

  // Observed state
  int cyc      = 0;
  int d_starts = 0;
  int d_dones  = 0;
  int d_wr     = 0;
  int e_val, e_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_start) d_starts++;
    if (frame_done) begin
      d_dones++;
      check("done_addr", int'(wr_addr), LAST);
      check("done_wr", int'(wr_en), 1);
    end
    if (wr_en) begin
      d_wr++;
      if (exp_q.size() == 0) begin
        check("extra_wr", int'(wr_addr), -1);
      end else begin
        e_val = exp_q.pop_front();
        e_cyc = exp_t.pop_front();
        check("wr_addr", int'(wr_addr), e_val >> 1);
        check("wr_data", int'(wr_data), e_val & 1);
        check("wr_lat", cyc - e_cyc, 2);
      end
    end
  end

  function automatic bit emits(input int i, input int n, input int d);
    return ((i+1)*n)/d > (i*n)/d;
  endfunction

  function automatic int thr_eff(input int row, input int col);
`ifdef MONO_STREAM_SCALER_DITHER_EN
    int t;
    t = m_thr + BAYER[(row%4)*4 + (col%4)]*16 - 120;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t;
`else
    return m_thr + 0*(row+col);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_frame_start();
    if (m_in_frame) m_short = 1;
    m_in_frame = 1;
    m_thr      = int'(threshold);
    m_line     = 0;
    m_starts++;
  endtask

  task automatic frame_start_pulse();
    vs = 1'b1;
    model_frame_start();
    repeat (3) tick();
    vs = 1'b0;
    repeat (2) tick();
    check("fs_short", int'(frame_short), int'(m_short));
    check("fs_count", d_starts, m_starts);
  endtask

  // mode 0 random, 1 grey 0x7F/0x80, 2 white
  task automatic send_line(input int len, input int abort_at,
                           input int rst_at, input int mode);
    int y, row, col, addr, v;
    bit le, live, d;
    y    = m_line;
    live = m_in_frame;
    if (live) m_line++;
    le  = live && (y < IN_H) && emits(y, OUT_H, IN_H);
    row = (y*OUT_H)/IN_H;
    for (int x = 0; x < len; x++) begin
      if (x == abort_at) begin
        vs = 1'b1;
        model_frame_start();
        live = 0;
      end
      if (x == rst_at) begin
        exp_q.delete();
        exp_t.delete();
        #2 reset = 1'b0;
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_start", int'(frame_start), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_addr", int'(wr_addr), 0);
        m_in_frame = 0;
        m_short    = 0;
        live       = 0;
        tick();
        tick();
        reset = 1'b1;
      end
      case (mode)
        1: begin
          v = $urandom_range(0, 1) ? 8'h80 : 8'h7F;
          r = 8'(v); g = 8'(v); b = 8'(v);
        end
        2: begin
          r = 8'hFF; g = 8'hFF; b = 8'hFF;
        end
        default: begin
          r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        end
      endcase
      de = 1'b1;
      if (live && le && m_in_frame && x < IN_W && emits(x, OUT_W, IN_W)) begin
        col  = (x*OUT_W)/IN_W;
        addr = row*OUT_W + col;
        d    = ((int'(r) + 2*int'(g) + int'(b))/4) >= thr_eff(row, col);
        if (enable) begin
          exp_q.push_back(addr*2 + int'(d));
          exp_t.push_back(cyc);
          m_wr++;
        end
        if (addr == LAST) begin
          m_in_frame = 0;
          m_short    = 0;
          m_dones++;
        end
      end
      tick();
    end
    de = 1'b0;
    vs = 1'b0;
    repeat (5) tick();
    check("line_drain", exp_q.size(), 0);
    check("short", int'(frame_short), int'(m_short));
    check("starts", d_starts, m_starts);
    check("dones", d_dones, m_dones);
  endtask

  task automatic run_lines(input int n, input int mode, input int off_lo,
                           input int off_hi, input bit jag);
    for (int y = 0; y < n; y++) begin
      enable = !(y >= off_lo && y <= off_hi);
      send_line(jag ? IN_W + int'($urandom_range(0, 3)) : IN_W, -1, -1, mode);
    end
    enable = 1'b1;
  endtask

  int wr_before;

  initial begin
    repeat (3) tick();
    check("rst_wr_en0", int'(wr_en), 0);
    check("rst_addr0", int'(wr_addr), 0);
    check("rst_data0", int'(wr_data), 0);
    check("rst_fs0", int'(frame_start), 0);
    check("rst_fd0", int'(frame_done), 0);
    check("rst_short0", int'(frame_short), 0);
    reset  = 1'b1;
    enable = 1'b1;
    tick();

    // de with no preceding vs
    send_line(IN_W, -1, -1, 0);

    // white frame, fixed threshold
    threshold = 8'h80;
    wr_before = d_wr;
    frame_start_pulse();
    run_lines(IN_H, 2, -1, -1, 0);
    check("white_writes", d_wr - wr_before, OUT_W*OUT_H);
    check("white_short", int'(frame_short), 0);

    // grey boundary pixels; threshold moves mid-frame
    threshold = 8'h80;
    frame_start_pulse();
    run_lines(4, 1, -1, -1, 0);
    threshold = 8'h00;
    run_lines(IN_H-4, 1, -1, -1, 0);

    // random frame, enable off for some lines, over-long lines
    threshold = 8'($urandom);
    frame_start_pulse();
    run_lines(IN_H, 0, 3, 6, 1);

    // short frame restarted between lines
    threshold = 8'($urandom);
    frame_start_pulse();
    run_lines(5, 0, -1, -1, 0);
    frame_start_pulse();
    check("short_set", int'(frame_short), 1);
    run_lines(IN_H, 0, -1, -1, 0);
    check("short_clr", int'(frame_short), 0);

    // vs edge mid-line
    frame_start_pulse();
    run_lines(3, 0, -1, -1, 0);
    send_line(IN_W, 7, -1, 0);
    check("abort_short", int'(frame_short), 1);
    run_lines(IN_H, 0, -1, -1, 0);
    check("abort_clr", int'(frame_short), 0);

    // reset mid-line, then de without vs, then a clean frame
    frame_start_pulse();
    run_lines(2, 0, -1, -1, 0);
    send_line(IN_W, -1, 9, 0);
    send_line(IN_W, -1, -1, 0);
    threshold = 8'($urandom);
    frame_start_pulse();
    run_lines(IN_H, 0, -1, -1, 0);

    check("total_wr", d_wr, m_wr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mono_stream_scaler.md
Name: mono_stream_scaler

Overview:
- Parametrised successor to the fixed 800x600->512x342 input path: one block does coordinate tracking, RGB->mono conversion and nearest-neighbour downscaling.
- It sits in the input pixel clock domain between the TFP401 video pins and the frame buffer write port.
- It emits framebuffer write strobes, linear addresses and 1-bit data for any IN_W x IN_H -> OUT_W x OUT_H downscale, using DDA accumulators (no dividers, no multipliers).
- It adds a programmable luma threshold and frame-integrity status.

Parameters:
- IN_W, 800, input active width in pixels.
- IN_H, 600, input active height in lines.
- OUT_W, 512, output width; must satisfy 1 <= OUT_W <= IN_W.
- OUT_H, 342, output height; must satisfy 1 <= OUT_H <= IN_H.
- ADDR_W, $clog2(OUT_W*OUT_H), framebuffer address width.
- VS_ACTIVE_HIGH, 1, vsync polarity; frame start is the leading edge of the active level.

Ports:
- clk  in  1  input pixel clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no writes are issued; state tracking continues.
- vs  in  1  vertical sync.
- de  in  1  data enable; high on active pixels.
- r  in  8  red channel.
- g  in  8  green channel.
- b  in  8  blue channel.
- threshold  in  8  luma threshold; sampled at frame start only.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  ADDR_W  linear address, out_y*OUT_W + out_x.
- wr_data  out  1  pixel value; 1 = white.
- frame_start  out  1  one-cycle pulse on the vs leading edge.
- frame_done  out  1  one-cycle pulse coincident with the write to address OUT_W*OUT_H-1.
- frame_short  out  1  sticky; set when a frame start arrives before frame_done; cleared by the next frame_done.

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulators, counters and threshold register are 0.
- Input registering:
  - Stage 0 registers vs, de, r, g, b.
  - Edge detection runs on the registered copies.
- Frame start (vs leading edge, stage 1):
  - Clear acc_y, out_y and the row-base address.
  - Latch threshold.
  - Pulse frame_start.
  - Set in_frame=1.
- Line start (de rising while in_frame), vertical DDA:
  - acc_y += OUT_H.
  - If acc_y >= IN_H: line_emit=1 and acc_y -= IN_H; otherwise line_emit=0.
  - Clear acc_x and out_x.
  - Input lines beyond IN_H in a frame are ignored (line_emit forced 0).
- Each de pixel, horizontal DDA:
  - acc_x += OUT_W.
  - If acc_x >= IN_W: pix_emit=1 and acc_x -= IN_W.
  - Pixels beyond IN_W in a line are ignored.
- Worked example (800->512): first emit at input x=1; exactly OUT_W emits per IN_W-pixel line.
- Line end (de falling after an emitting line): out_y += 1 and row_base += OUT_W.
- Luma and mono decision:
  - luma = (r + 2g + b) >> 2, computed in 10 bits before the shift.
  - mono = (luma >= threshold_latched).
- Write output:
  - wr_en = line_emit & pix_emit & enable & in_frame.
  - Registered; latency is 2 clocks from the de-qualified input pixel to wr_en/wr_addr/wr_data.
  - wr_addr = row_base + out_x, running sum; out_x increments after each emitted pixel.
- Frame completion:
  - The write with out_y==OUT_H-1 and out_x==OUT_W-1 pulses frame_done, clears in_frame, and suppresses further writes until the next frame start.
- Boundary conditions:
  - vs edge mid-line: the frame restarts immediately and the current line is abandoned; frame_short=1 if frame_done has not occurred.
  - de with no prior vs: ignored (in_frame=0).
  - enable deasserted mid-frame: writes are masked, but counters advance so addresses stay aligned when re-enabled.
  - Reset mid-frame: outputs drop to 0 asynchronously; the block waits for the next vs.

Optional Feature:
- Macro: MONO_STREAM_SCALER_DITHER_EN.
- Defined: the threshold compare uses threshold_latched + bayer4x4[out_y[1:0]][out_x[1:0]]*16 - 120, saturating to 0..255. Bayer matrix is the standard 0..15 ordering. Latency is unchanged.
- Undefined: plain fixed threshold; no dither logic is synthesised.

Test Plan:
- Default parameters, full 800x600 frame, all pixels rgb=FFFFFF, threshold=0x80 -> exactly 175104 wr_en pulses, all wr_data=1, addresses 0..175103 monotonic, one frame_done, frame_short=0.
- Single line, de held 800 cycles -> first wr_en 2 clocks after input x=1 with wr_addr=0; 512 writes total on that line.
- Pixels r=g=b=0x7F then 0x80, threshold=0x80 -> wr_data 0 then 1; threshold change mid-frame has no effect until the next frame_start.
- vs edge after 300 input lines -> frame_start pulse, frame_short=1, next write goes to wr_addr=0; a subsequent full frame clears frame_short at frame_done.
- enable=0 for lines 100-199 -> no writes on those output rows; the first write after re-enable carries the correct row_base (out_y*512).
- Reset asserted mid-line -> wr_en=0 immediately; no writes until the next vs leading edge.
